sprite_linebuf_writer: RTL and testbench
========================================

# sprite_linebuf_writer

Sprite-side write engine for the scanline buffer. Accepts one 16-pixel, 4bpp sprite row per handshake and stores it into the line buffer's write port with per-pixel read-modify-write: transparent pixels are skipped, and already-occupied pixels are kept, so the first sprite written wins. It sits between the sprite fetch/scan logic and the write port of the scanline buffer; the video side reads and clears the other port.

## Interface
- `LINE_W`, 256: visible line width in pixels; addresses >= LINE_W are clipped.
- `AW`, 10: line buffer address width.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  sprite row request valid.
- `req_ready`  out  1  high only in IDLE; transfer on `req_valid & req_ready` at a rising edge.
- `req_x`  in  AW  left pixel address of the row.
- `req_bank`  in  7  color bank; becomes `lb_dat[10:4]`.
- `req_pix`  in  64  pixel i = `req_pix[4i+3:4i]`; 0 = transparent.
- `req_flip`  in  1  horizontal flip.
- `lb_adr`  out  AW  line buffer write-port address.
- `lb_dat`  out  11  write data `{bank, nibble}`.
- `lb_we`  out  1  write enable.
- `lb_rdat`  in  11  registered readback from the write port, valid one cycle after `lb_adr` is presented with `lb_we=0`.
- `busy`  out  1  high from the accept edge until DONE exits.
- `done`  out  1  one-cycle pulse per completed row.
- `coll`  out  1  sticky collision flag (see Configuration).
- `coll_clr`  in  1  synchronous clear of `coll`.

## Operation
- States: IDLE -> RD -> WR -> (RD, next pixel | DONE) -> IDLE.
- IDLE: `req_ready=1`. On accept, latch x, bank, pix and flip; set pixel index p=0; go to RD.
- RD: `lb_adr = x+p` (AW-bit truncation), `lb_we=0`.
- WR: nibble n = flip ? pix[15-p] : pix[p]. Clip when the AW+1-bit sum x+p >= LINE_W.
  - `lb_we = (n!=0) & !clip & (lb_rdat[3:0]==0)`, `lb_dat = {bank, n}`. `lb_adr` is held from RD.
  - If p==15, go to DONE; otherwise p+1 and go to RD.
- DONE: `done=1` for one cycle, `lb_we=0`, then IDLE.
- Clipped and transparent pixels still take their RD/WR slots. Each row has a fixed cost.
- Data already in the buffer with `[3:0]!=0` is never overwritten.
- Reset values: `req_ready=1` (IDLE), `lb_adr=0`, `lb_dat=0`, `lb_we=0`, `busy=0`, `done=0`, `coll=0`. All outputs are registered.
- Reset mid-row: abort immediately. `lb_we` drops asynchronously, no further writes, latched request discarded.

## Timing
- Accept at edge 0. RD for pixel p in cycle 1+2p; WR in cycle 2+2p.
- `done` in cycle 33; `req_ready` high again in cycle 34. Throughput is 1 row per 34 cycles.
- `req_valid` during busy is ignored and not queued. The source holds it until `req_ready`.
- `lb_rdat` is sampled in WR only. The bench model returns the stored word one cycle after a read address.

## Configuration
- `SPRLB_COLL_EN` defined:
  - `coll` sets in any WR cycle where `n!=0`, `!clip` and `lb_rdat[3:0]!=0`.
  - `coll_clr` clears it. If set and clear occur in the same cycle, set wins.
  - Clipped pixels never set it.
- `SPRLB_COLL_EN` undefined: `coll` is constant 0 and `coll_clr` is ignored. Write behaviour is identical.

## Test plan
- Empty buffer, x=16, bank=7'h05, pix=64'h0000_0000_0000_0021, flip=0 -> exactly two writes: addr 16 = 11'h051, addr 17 = 11'h052; `done` in cycle 33; `coll=0`.
- Same row with flip=1 -> addr 30 = 11'h052, addr 31 = 11'h051; no other writes.
- Buffer pre-loaded with addr 20 = 11'h0A3, row x=16, all pixels 4'hF -> addr 20 unchanged, 15 writes total.
  - With `SPRLB_COLL_EN`: `coll=1`. After `coll_clr`: `coll=0`.
- LINE_W=256, x=250, all pixels opaque -> writes only at addrs 250..255; no write at 256..265; still 34 cycles.
- `req_valid` held high continuously -> accepts at cycles 0, 34, 68; `req_ready` low in between.
- Assert `reset` during cycle 10 of a row -> `lb_we` goes 0 at once, no further writes, `req_ready=1` after release, next request processed normally.

Source files
------------

// File: rtl/sprite_linebuf_writer.sv
// sprite_linebuf_writer
//
// This block is the sprite-side write engine for the scanline buffer. It takes one 16-pixel,
// 4bpp sprite row per handshake. For each pixel it reads the buffer, then writes it back.
// Transparent pixels (nibble 0) are skipped. Occupied locations (stored [3:0] != 0) are kept,
// so the first sprite written to a pixel wins. Every row costs a fixed 34 cycles, whether
// its pixels are drawn, clipped or transparent.
//
// Optional feature: define SPRLB_COLL_EN to enable the sticky collision flag.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   req_valid  sprite row request valid
//   req_ready  high only while idle
//   req_x      left pixel address of the row
//   req_bank   colour bank, stored as lb_dat[10:4]
//   req_pix    16 nibbles, pixel i = req_pix[4i+3:4i], 0 = transparent
//   req_flip   horizontal flip
//   lb_adr     line buffer write-port address
//   lb_dat     write data {bank, nibble}
//   lb_we      write enable
//   lb_rdat    registered readback, valid one cycle after a read address
//   busy       high from accept until the row completes
//   done       one-cycle pulse per completed row
//   coll       sticky collision flag (constant 0 without SPRLB_COLL_EN)
//   coll_clr   synchronous clear of coll
module sprite_linebuf_writer #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned AW     = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_x,
  input  logic [6:0]    req_bank,
  input  logic [63:0]   req_pix,
  input  logic          req_flip,
  output logic [AW-1:0] lb_adr,
  output logic [10:0]   lb_dat,
  output logic          lb_we,
  input  logic [10:0]   lb_rdat,
  output logic          busy,
  output logic          done,
  output logic          coll,
  input  logic          coll_clr
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] x_q, x_d;
  logic [6:0]    bank_q, bank_d;
  logic [63:0]   pix_q, pix_d;
  logic          flip_q, flip_d;
  logic [3:0]    p_q, p_d;

  logic          req_ready_q, req_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [AW-1:0] lb_adr_q, lb_adr_d;
  logic [10:0]   lb_dat_q, lb_dat_d;
  logic          wr_cand_q, wr_cand_d;

  logic [3:0]    nib_idx;
  logic [3:0]    nib;
  logic [AW:0]   pix_sum;
  logic          clip;
  logic          occupied;

  // Current pixel, evaluated from the latched row and the current index.
  always_comb begin
    nib_idx = flip_q ? (4'd15 - p_q) : p_q;
    nib     = pix_q[{nib_idx, 2'b00} +: 4];
    pix_sum = {1'b0, x_q} + {{(AW - 3){1'b0}}, p_q};
    clip    = pix_sum >= (AW + 1)'(LINE_W);
  end

  assign occupied = lb_rdat[3:0] != 4'd0;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = StRd;
      StRd:    state_d = StWr;
      StWr:    state_d = (p_q == 4'd15) ? StDone : StRd;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Row latch and pixel index
  always_comb begin
    x_d    = x_q;
    bank_d = bank_q;
    pix_d  = pix_q;
    flip_d = flip_q;
    p_d    = p_q;
    if (state_q == StIdle && req_valid) begin
      x_d    = req_x;
      bank_d = req_bank;
      pix_d  = req_pix;
      flip_d = req_flip;
      p_d    = 4'd0;
    end else if (state_q == StWr && p_q != 4'd15) begin
      p_d = p_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q    <= '0;
      bank_q <= '0;
      pix_q  <= '0;
      flip_q <= 1'b0;
      p_q    <= '0;
    end else begin
      x_q    <= x_d;
      bank_q <= bank_d;
      pix_q  <= pix_d;
      flip_q <= flip_d;
      p_q    <= p_d;
    end
  end

  // Output logic. These are the next values of the registered outputs, decoded from state_d.
  always_comb begin
    req_ready_d = state_d == StIdle;
    busy_d      = state_d != StIdle;
    done_d      = state_d == StDone;
    lb_adr_d    = lb_adr_q;
    lb_dat_d    = lb_dat_q;
    wr_cand_d   = 1'b0;
    if (state_d == StRd) begin
      lb_adr_d = x_d + AW'(p_d);
    end
    if (state_d == StWr) begin
      lb_dat_d  = {bank_q, nib};
      wr_cand_d = (nib != 4'd0) && !clip;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      lb_adr_q    <= '0;
      lb_dat_q    <= '0;
      wr_cand_q   <= 1'b0;
    end else begin
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      lb_adr_q    <= lb_adr_d;
      lb_dat_q    <= lb_dat_d;
      wr_cand_q   <= wr_cand_d;
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign lb_adr    = lb_adr_q;
  assign lb_dat    = lb_dat_q;
  // The readback only becomes valid in the WR cycle itself, so the registered write candidate
  // is qualified by it directly. A reset clears wr_cand_q, which drops lb_we at once.
  assign lb_we     = wr_cand_q & ~occupied;

`ifdef SPRLB_COLL_EN
  logic coll_q, coll_d;

  // A set in the same cycle as a clear takes priority.
  always_comb begin
    coll_d = coll_q;
    if (coll_clr) coll_d = 1'b0;
    if (wr_cand_q && occupied) coll_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coll_q <= 1'b0;
    end else begin
      coll_q <= coll_d;
    end
  end

  assign coll = coll_q;
`else
  logic unused_coll_clr;
  assign unused_coll_clr = coll_clr;
  assign coll = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_linebuf_writer.sv
// Self-checking bench for sprite_linebuf_writer. The bench models the line buffer memory
// (registered readback) and keeps an independent reference picture of it. The reference
// picture is built from the sprite compositing rules.
module tb_sprite_linebuf_writer;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned AW     = 10;
  localparam int          DEPTH  = 1 << AW;
`ifdef SPRLB_COLL_EN
  localparam bit CollEn = 1'b1;
`else
  localparam bit CollEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_x = '0;
  logic [6:0]    req_bank = '0;
  logic [63:0]   req_pix = '0;
  logic          req_flip = 1'b0;
  logic [AW-1:0] lb_adr;
  logic [10:0]   lb_dat;
  logic          lb_we;
  logic [10:0]   lb_rdat;
  logic          busy;
  logic          done;
  logic          coll;
  logic          coll_clr = 1'b0;

  sprite_linebuf_writer #(.LINE_W(LINE_W), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_x    (req_x),
    .req_bank (req_bank),
    .req_pix  (req_pix),
    .req_flip (req_flip),
    .lb_adr   (lb_adr),
    .lb_dat   (lb_dat),
    .lb_we    (lb_we),
    .lb_rdat  (lb_rdat),
    .busy     (busy),
    .done     (done),
    .coll     (coll),
    .coll_clr (coll_clr)
  );

  always #5 clk = ~clk;

  // Line buffer memory model
  logic [10:0]   mem [DEPTH];
  logic          tb_clr = 1'b1;
  logic          tb_pre_we = 1'b0;
  logic [AW-1:0] tb_pre_adr = '0;
  logic [10:0]   tb_pre_dat = '0;
  int            wr_cnt = 0;
  int            bad_wr_cnt = 0;
  int            cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tb_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (tb_pre_we) begin
      mem[tb_pre_adr] <= tb_pre_dat;
    end else if (lb_we === 1'b1) begin
      mem[lb_adr] <= lb_dat;
      wr_cnt <= wr_cnt + 1;
      if (int'(lb_adr) >= int'(LINE_W)) bad_wr_cnt <= bad_wr_cnt + 1;
    end
    lb_rdat <= mem[lb_adr];
  end

  // Reference picture and bookkeeping
  logic [10:0] ref_mem [DEPTH];
  bit          exp_coll = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Composite pixels 0..npix-1 of a row into the reference picture.
  task automatic model_row(input int x, input logic [6:0] bank, input logic [63:0] pix,
                           input bit flip, input int npix, output int nwr);
    nwr = 0;
    for (int p = 0; p < npix; p++) begin
      int          idx;
      int          a;
      logic [63:0] sh;
      logic [3:0]  n;
      idx = flip ? 15 - p : p;
      sh  = pix >> (4 * idx);
      n   = sh[3:0];
      a   = x + p;
      if (n != 4'd0 && a < int'(LINE_W)) begin
        if (ref_mem[a][3:0] == 4'd0) begin
          ref_mem[a] = {bank, n};
          nwr++;
        end else begin
          exp_coll = 1'b1;
        end
      end
    end
  endtask

  task automatic cmp_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
    check_eq(tag, bad, 0);
  endtask

  task automatic clear_buf();
    @(posedge clk); #1 tb_clr = 1'b1;
    @(posedge clk); #1 tb_clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic preload(input int a, input logic [10:0] d);
    @(posedge clk); #1 tb_pre_we = 1'b1; tb_pre_adr = AW'(a); tb_pre_dat = d;
    @(posedge clk); #1 tb_pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic pulse_coll_clr();
    @(posedge clk); #1 coll_clr = 1'b1;
    @(posedge clk); #1 coll_clr = 1'b0;
    exp_coll = 1'b0;
    @(negedge clk);
    check_eq("coll_after_clr", coll, 1'b0);
  endtask

  task automatic run_row(input logic [AW-1:0] x, input logic [6:0] bank, input logic [63:0] pix,
                         input bit flip);
    int w0, done_cyc, rdy_cyc, done_n, exp_w;
    done_cyc = -1; rdy_cyc = -1; done_n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_x = x; req_bank = bank; req_pix = pix; req_flip = flip;
    @(negedge clk);
    check_eq("ready_before_accept", req_ready, 1'b1);
    w0 = wr_cnt;
    @(posedge clk); #1 req_valid = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check_eq("rd0_adr", lb_adr, x);
        check_eq("rd0_we", lb_we, 1'b0);
        check_eq("busy", busy, 1'b1);
      end
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (req_ready) begin
        rdy_cyc = c;
        break;
      end
    end
    model_row(int'(x), bank, pix, flip, 16, exp_w);
    check_eq("done_cycle", done_cyc, 33);
    check_eq("done_width", done_n, 1);
    check_eq("ready_cycle", rdy_cyc, 34);
    check_eq("write_count", wr_cnt - w0, exp_w);
    cmp_mem("buffer_contents");
    check_eq("coll", coll, CollEn ? exp_coll : 1'b0);
  endtask

  function automatic logic [63:0] rand_pix();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) v[4*i +: 4] = 4'($urandom_range(1, 15));
    end
    return v;
  endfunction

  initial begin
    int acc [3];
    int n_acc, low_cnt, guard, w0, dummy;
    logic [63:0] pix;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", req_ready, 1'b1);
    check_eq("rst_outputs", {lb_adr, lb_dat, lb_we, busy, done, coll}, '0);
    #1 tb_clr = 1'b0; reset = 1'b0;

    // Two opaque pixels, no flip and then flipped
    run_row(AW'(16), 7'h05, 64'h21, 1'b0);
    check_eq("t1_addr16", mem[16], 11'h051);
    check_eq("t1_addr17", mem[17], 11'h052);
    clear_buf();
    run_row(AW'(16), 7'h05, 64'h21, 1'b1);
    check_eq("t2_addr30", mem[30], 11'h052);
    check_eq("t2_addr31", mem[31], 11'h051);

    // Occupied pixel is preserved
    clear_buf();
    preload(20, 11'h0A3);
    run_row(AW'(16), 7'h11, {16{4'hF}}, 1'b0);
    check_eq("t3_addr20_kept", mem[20], 11'h0A3);
    pulse_coll_clr();

    // Right-edge clipping
    clear_buf();
    run_row(AW'(250), 7'h3C, {16{4'h7}}, 1'b0);
    check_eq("clip_no_write_past_edge", bad_wr_cnt, 0);

    // req_valid held high: back-to-back accepts 34 cycles apart
    clear_buf();
    pix = rand_pix() | 64'h1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_x = AW'(40); req_bank = 7'h2A; req_pix = pix; req_flip = 1'b0;
    n_acc = 0; low_cnt = 0; guard = 0;
    while (n_acc < 3 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (req_ready) begin
        acc[n_acc] = cyc + 1;
        n_acc++;
      end else if (n_acc > 0) begin
        low_cnt++;
      end
    end
    @(posedge clk); #1 req_valid = 1'b0;
    guard = 0;
    while (!req_ready && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check_eq("hold_accept_count", n_acc, 3);
    check_eq("hold_gap1", acc[1] - acc[0], 34);
    check_eq("hold_gap2", acc[2] - acc[1], 34);
    check_eq("hold_ready_low", low_cnt, 66);
    for (int k = 0; k < 3; k++) model_row(40, 7'h2A, pix, 1'b0, 16, dummy);
    cmp_mem("hold_buffer");
    check_eq("hold_coll", coll, CollEn ? exp_coll : 1'b0);
    pulse_coll_clr();

    // Reset during WR of pixel 4 (cycle 10)
    clear_buf();
    pix = {16{4'h9}};
    @(posedge clk); #1;
    req_valid = 1'b1; req_x = AW'(100); req_bank = 7'h55; req_pix = pix; req_flip = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("we_before_reset", lb_we, 1'b1);
    #1 reset = 1'b1;
    #1;
    check_eq("we_async_drop", lb_we, 1'b0);
    check_eq("ready_in_reset", req_ready, 1'b1);
    check_eq("busy_in_reset", busy, 1'b0);
    w0 = wr_cnt;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("no_write_after_reset", wr_cnt - w0, 0);
    check_eq("ready_after_reset", req_ready, 1'b1);
    model_row(100, 7'h55, pix, 1'b0, 4, dummy);
    exp_coll = 1'b0;
    cmp_mem("reset_buffer");
    run_row(AW'(120), 7'h0F, rand_pix(), 1'b1);

    // Randomized rows against the reference picture
    for (int r = 0; r < 20; r++) begin
      logic [AW-1:0] rx;
      if (r % 5 == 0) clear_buf();
      if ($urandom_range(0, 9) < 7) rx = AW'($urandom_range(0, LINE_W + 20));
      else rx = AW'($urandom_range(0, DEPTH - 1));
      run_row(rx, 7'($urandom_range(0, 127)), rand_pix(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) pulse_coll_clr();
    end
    check_eq("no_write_past_edge", bad_wr_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
